// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MD_UNIT_MADD_EN to enable MADD (op 6) and MSUB (op 7); otherwise those ops are no-ops.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [2:0]         op_q, op_next;
  logic [WIDTH-1:0]   a_q, a_next;
  logic [WIDTH-1:0]   b_q, b_next;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic               done_next;

  logic               op_is_mul;
  logic               op_is_div;

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_div;
  logic [WIDTH-1:0]   q_mag, r_mag;
  logic [WIDTH-1:0]   quo, rem;

  logic [2*WIDTH-1:0] result;

  always_comb begin
    op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_UNIT_MADD_EN
    op_is_mul = op_is_mul || (op == OP_MADD) || (op == OP_MSUB);
`endif
  end

  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);

  // Extending both operands to 2*WIDTH lets one plain multiplier give the exact product
  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign a_zx   = {{WIDTH{1'b0}}, a_q};
  assign b_zx   = {{WIDTH{1'b0}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide runs on magnitudes; most-negative / -1 falls out as lo=a, hi=0
  assign a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
  assign b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
  assign a_mag = a_neg ? (~a_q + WIDTH'(1)) : a_q;
  assign b_mag = b_neg ? (~b_q + WIDTH'(1)) : b_q;
  assign b_div = (b_q == '0) ? WIDTH'(1) : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;

  always_comb begin
    quo = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end
  end

  always_comb begin
    result = {hi, lo};
    case (op_q)
      OP_MULT:          result = prod_s;
      OP_MULTU:         result = prod_u;
      OP_DIV, OP_DIVU:  result = {rem, quo};
`ifdef MD_UNIT_MADD_EN
      OP_MADD:          result = {hi, lo} + prod_s;
      OP_MSUB:          result = {hi, lo} - prod_s;
`endif
      default:          result = {hi, lo};
    endcase
  end

  // Next-state logic: starts are only honoured in IDLE, and HI/LO only move on completion or MTHI/MTLO
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = op_q;
    a_next     = a_q;
    b_next     = b_q;
    hi_next    = hi;
    lo_next    = lo;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_is_mul || op_is_div) begin
            op_next    = op;
            a_next     = a;
            b_next     = b;
            cnt_next   = op_is_div ? DIV_LOAD : MULT_LOAD;
            state_next = RUN;
          end else if (op == OP_MTHI) begin
            hi_next = a;
          end else if (op == OP_MTLO) begin
            lo_next = a;
          end
        end
      end
      RUN: begin
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          {hi_next, lo_next} = result;
          done_next          = 1'b1;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
      a_q   <= a_next;
      b_q   <= b_next;
      hi    <= hi_next;
      lo    <= lo_next;
      done  <= done_next;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit at default parameters (WIDTH=32, 5/10 cycles).
// Define MD_UNIT_MADD_EN for both bench and design to exercise MADD.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Issues one op, counts busy cycles, and checks done pulses exactly once after busy drops
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cycles, output bit pulse_ok);
    bit early;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    early  = 1'b0;
    while (busy && cycles < 200) begin
      cycles++;
      if (done) early = 1'b1;
      @(negedge clk);
    end
    pulse_ok = done && !early;
    @(negedge clk);
    if (done) pulse_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int c; bit p;
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, c, p);
    check_int("mult_busy_cycles", c, 5);
    check_int("mult_done_pulse", int'(p), 1);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, c, p);
    check_int("multu_busy_cycles", c, 5);
    check32("multu_hi", hi, 32'h0000_0001);
    check32("multu_lo", lo, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    int c; bit p;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, c, p);
    check_int("div_busy_cycles", c, 10);
    check_int("div_done_pulse", int'(p), 1);
    check32("div_lo", lo, 32'hFFFF_FFFD);
    check32("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd100, 32'd7, c, p);
    check32("divu_lo", lo, 32'd14);
    check32("divu_hi", hi, 32'd2);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, c, p);
    check32("div_negb_lo", lo, 32'hFFFF_FFFD);
    check32("div_negb_hi", hi, 32'd1);
  endtask

  task automatic test_div_edge();
    int c; bit p;
    run_op(3'd3, 32'h0000_1234, 32'd0, c, p);
    check_int("divz_busy_cycles", c, 10);
    check_int("divz_done_pulse", int'(p), 1);
    check32("divz_hi", hi, 32'h0000_1234);
    check32("divz_lo", lo, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0, c, p);
    check32("divz_signed_hi", hi, 32'hFFFF_FFFB);
    check32("divz_signed_lo", lo, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, c, p);
    check32("divovf_lo", lo, 32'h8000_0000);
    check32("divovf_hi", hi, 32'h0);
  endtask

  task automatic test_ignore_busy();
    int c; bit p;
    run_op(3'd4, 32'h0000_000A, 32'd0, c, p);
    run_op(3'd5, 32'h0000_000B, 32'd0, c, p);
    check_int("mthi_no_busy", c, 0);
    check32("mthi_hi", hi, 32'h0000_000A);
    check32("mtlo_lo", lo, 32'h0000_000B);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd2;
    @(negedge clk);
    c = 0;
    if (busy) c++;
    op = 3'd5; a = 32'h55;
    @(negedge clk);
    if (busy) c++;
    op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    if (busy) c++;
    start = 1'b0;
    check32("run_hold_hi", hi, 32'h0000_000A);
    check32("run_hold_lo", lo, 32'h0000_000B);
    @(negedge clk);
    while (busy && c < 200) begin
      c++;
      @(negedge clk);
    end
    check_int("ignore_busy_cycles", c, 5);
    check32("ignore_hi", hi, 32'hFFFF_FFFF);
    check32("ignore_lo", lo, 32'hFFFF_FFFE);
    @(negedge clk);
    check_int("ignore_no_restart", int'(busy), 0);
    run_op(3'd5, 32'h55, 32'd0, c, p);
    check_int("mtlo_idle_busy", c, 0);
    check_int("mtlo_idle_done", int'(done), 0);
    check32("mtlo_idle_lo", lo, 32'h55);
    check32("mtlo_idle_hi", hi, 32'hFFFF_FFFF);
  endtask

  task automatic test_async_reset();
    int c; bit p;
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_int("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check32("async_reset_hi", hi, 32'h0);
    check32("async_reset_lo", lo, 32'h0);
    check_int("async_reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_int("held_reset_busy", int'(busy), 0);
    run_op(3'd1, 32'd7, 32'd6, c, p);
    check_int("post_reset_cycles", c, 5);
    check_int("post_reset_done", int'(p), 1);
    check32("post_reset_hi", hi, 32'h0);
    check32("post_reset_lo", lo, 32'd42);
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (busy && c < 200) begin
      c++;
      @(negedge clk);
    end
    check_int("b2b_first_cycles", c, 10);
    check_int("b2b_first_done", int'(done), 1);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check_int("b2b_second_busy", int'(busy), 1);
    check32("b2b_hold_hi", hi, 32'd2);
    check32("b2b_hold_lo", lo, 32'd14);
    c = 0;
    while (busy && c < 200) begin
      c++;
      @(negedge clk);
    end
    check_int("b2b_second_cycles", c, 5);
    check32("b2b_hi", hi, 32'd0);
    check32("b2b_lo", lo, 32'd15);
  endtask

  task automatic test_madd();
    int c; bit p;
    run_op(3'd4, 32'd0, 32'd0, c, p);
    run_op(3'd5, 32'd10, 32'd0, c, p);
    run_op(3'd6, 32'd3, 32'hFFFF_FFFE, c, p);
`ifdef MD_UNIT_MADD_EN
    check_int("madd_cycles", c, 5);
    check32("madd_hi", hi, 32'd0);
    check32("madd_lo", lo, 32'd4);
    run_op(3'd7, 32'd3, 32'hFFFF_FFFE, c, p);
    check32("msub_hi", hi, 32'd0);
    check32("msub_lo", lo, 32'd10);
`else
    check_int("madd_off_cycles", c, 0);
    check32("madd_off_hi", hi, 32'd0);
    check32("madd_off_lo", lo, 32'd10);
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_ignore_busy();
    test_async_reset();
    test_back_to_back();
    test_madd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
